// File: rtl/lab5_pkg.sv
// lab5_pkg: constants shared by the lab5 data-memory I/O map and its input conditioner
package lab5_pkg;
    localparam int IO_WIDTH = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    typedef logic [IO_WIDTH-1:0] io_word_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, per-bit debounce counter and accepted-level flop for one input
module debounce_bit
    import lab5_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The counter judges the value entering sync2, so an accepted level lands
    // together with sync2 and DEBOUNCE_CYCLES=1 degenerates to a bare synchronizer.
    assign accept = (sync1 != level) && (cnt == LAST);
    assign rise   = accept && sync1;

    // Two-flop synchronizer plus run-length counter that only lets a new level through
    // after DEBOUNCE_CYCLES consecutive identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // sync2 mirrors the synchronized input for anyone probing the chain; the
    // debounce path itself never needs it once sync1 has been judged.
    logic unused_sync2;
    assign unused_sync2 = sync2;
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: debounced levels and sticky rising-edge flags for the IOA/IOB windows
module io_input_conditioner
    import lab5_pkg::*;
#(
    parameter int WIDTH           = IO_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] RAW,
    input  logic             RD_EDGE,
    output logic [WIDTH-1:0] LEVEL,
    output logic [WIDTH-1:0] EDGE,
    output logic             CHANGED
);
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] level_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (CLK),
            .rst_n(RESET),
            .raw  (RAW[i]),
            .level(LEVEL[i]),
            .rise (rise[i])
        );
    end

    // Sticky edge flags cleared by a CPU read, with a simultaneous rise winning;
    // CHANGED trails any LEVEL update by one cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            EDGE    <= '0;
            level_q <= '0;
            CHANGED <= 1'b0;
        end else begin
            EDGE    <= (EDGE & ~{WIDTH{RD_EDGE}}) | rise;
            level_q <= LEVEL;
            CHANGED <= |(LEVEL ^ level_q);
        end
    end
endmodule
